// File: rtl/store_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | store_buffer_pkg                                                           |
// | Shared types and constants for the posted-store buffer.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package store_buffer_pkg;

  typedef enum logic [1:0] {
    DR_IDLE  = 2'd0,
    DR_ISSUE = 2'd1,
    DR_WAIT  = 2'd2
  } dr_state_t;

  localparam int          SM_SIGN  = 3;
  localparam int          SM_WORD  = 2;
  localparam int          SM_HALF  = 1;
  localparam logic [31:0] LED_ADDR = 32'h0000_2000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/store_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | store_fifo                                                                 |
// | DEPTH x 68-bit store queue exposing per-entry word addresses for hazards.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module store_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  sb_entry_t                     push_entry,
  input  logic                          pop,
  output sb_entry_t                     head_entry,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic [DEPTH-1:0][AW-1:0]      entry_waddr,
  output logic [DEPTH-1:0]              entry_valid
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t        r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_count;
  logic [DEPTH-1:0] r_valid;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (PW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Pointers are exactly PW bits wide, so wrap at DEPTH is free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (w_pop && (r_head == PW'(i)))  r_valid[i] <= 1'b0;
        if (w_push && (r_tail == PW'(i))) r_valid[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= push_entry;
  end

  assign head_entry  = r_mem[r_head];
  assign count       = r_count;
  assign entry_valid = r_valid;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_taps
    assign entry_waddr[gi] = r_mem[gi].addr[AW+1:2];
  end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | store_buffer                                                               |
// | Posted-store buffer owning the data_mem port: hazard check, mux, drain.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  sign_mask,
  output logic [31:0] read_data,
  output logic        clk_stall,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_write_data,
  output logic        dm_memwrite,
  output logic        dm_memread,
  output logic [3:0]  dm_sign_mask,
  input  logic [31:0] dm_read_data,
  input  logic        dm_clk_stall
);

  dr_state_t                  r_state;
  dr_state_t                  w_state_nxt;
  sb_entry_t                  w_head;
  sb_entry_t                  w_new;
  logic                       w_full;
  logic                       w_empty;
  logic [$clog2(DEPTH):0]     w_count;
  logic [DEPTH-1:0][AW-1:0]   w_waddr;
  logic [DEPTH-1:0]           w_valid;
  logic                       w_store;
  logic                       w_load;
  logic                       w_match;
  logic                       w_load_go;
  logic                       w_head_sel;
  logic                       w_push;
  logic                       w_pop;

  assign w_store = memwrite;
  assign w_load  = memread & ~memwrite;
  assign w_new   = '{addr: addr, data: write_data, mask: sign_mask};
  assign w_push  = w_store & ~w_full;
  assign w_pop   = (r_state == DR_ISSUE);

  store_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (w_push),
    .push_entry  (w_new),
    .pop         (w_pop),
    .head_entry  (w_head),
    .full        (w_full),
    .empty       (w_empty),
    .count       (w_count),
    .entry_waddr (w_waddr),
    .entry_valid (w_valid)
  );

  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_waddr[i] == addr[AW+1:2])) w_match = 1'b1;
    end
    w_match = w_match & (w_count != '0);
  end

  // An unstalled load owns the port only from IDLE; an ISSUE is never preempted.
  assign w_load_go  = w_load & ~w_match & (r_state == DR_IDLE) & ~dm_clk_stall;
  assign w_head_sel = (r_state == DR_IDLE) & ~dm_clk_stall & ~w_load_go & ~w_empty;

  assign clk_stall = (w_store & w_full)
                   | (w_load & w_match)
                   | (w_load & ((r_state != DR_IDLE) | dm_clk_stall));
  assign read_data = dm_read_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= DR_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    dm_addr       = '0;
    dm_write_data = '0;
    dm_memwrite   = 1'b0;
    dm_memread    = 1'b0;
    dm_sign_mask  = '0;
    case (r_state)
      DR_IDLE: begin
        if (w_load_go) begin
          dm_addr      = addr;
          dm_memread   = 1'b1;
          dm_sign_mask = sign_mask;
        end else if (w_head_sel) begin
          dm_addr       = w_head.addr;
          dm_write_data = w_head.data;
          dm_sign_mask  = w_head.mask;
          w_state_nxt   = DR_ISSUE;
        end
      end
      DR_ISSUE: begin
        dm_addr       = w_head.addr;
        dm_write_data = w_head.data;
        dm_sign_mask  = w_head.mask;
        dm_memwrite   = 1'b1;
        w_state_nxt   = DR_WAIT;
      end
      DR_WAIT: begin
        if (!dm_clk_stall) w_state_nxt = DR_IDLE;
      end
      default: w_state_nxt = DR_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_store_buffer                                                            |
// | Directed bench with a data_mem model and a program-order reference memory. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int          DEPTH = 4;
  localparam int          AW    = 10;
  localparam logic [3:0]  M_SW  = 4'b0100;
  localparam logic [3:0]  M_LW  = 4'b1100;
  localparam logic [3:0]  M_LBU = 4'b0000;
  localparam logic [3:0]  M_SB  = 4'b0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [3:0]  sign_mask = '0;
  logic [31:0] read_data;
  logic        clk_stall;
  logic [31:0] dm_addr;
  logic [31:0] dm_write_data;
  logic        dm_memwrite;
  logic        dm_memread;
  logic [3:0]  dm_sign_mask;
  logic [31:0] dm_read_data;
  logic        dm_clk_stall;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .addr          (addr),
    .write_data    (write_data),
    .memwrite      (memwrite),
    .memread       (memread),
    .sign_mask     (sign_mask),
    .read_data     (read_data),
    .clk_stall     (clk_stall),
    .dm_addr       (dm_addr),
    .dm_write_data (dm_write_data),
    .dm_memwrite   (dm_memwrite),
    .dm_memread    (dm_memread),
    .dm_sign_mask  (dm_sign_mask),
    .dm_read_data  (dm_read_data),
    .dm_clk_stall  (dm_clk_stall)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                        input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    w = old;
    if (m[2])      w = d;
    else if (m[1]) begin
      if (a[1]) w[31:16] = d[15:0];
      else      w[15:0]  = d[15:0];
    end else       w[int'(a[1:0])*8 +: 8] = d[7:0];
    return w;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [31:0] a,
                                          input logic [3:0] m);
    logic [15:0] h;
    logic [7:0]  b;
    if (m[2]) return w;
    if (m[1]) begin
      h = a[1] ? w[31:16] : w[15:0];
      return m[3] ? {{16{h[15]}}, h} : {16'h0, h};
    end
    b = w[int'(a[1:0])*8 +: 8];
    return m[3] ? {{24{b[7]}}, b} : {24'h0, b};
  endfunction

  // data_mem model: one busy cycle after each accepted write, registered reads.
  logic [31:0] dmem    [4096];
  logic [31:0] ref_mem [4096];
  logic        r_dm_busy = 1'b0;
  logic        hold_busy = 1'b0;
  logic [31:0] r_dm_rd = '0;

  assign dm_clk_stall = r_dm_busy | hold_busy;
  assign dm_read_data = r_dm_rd;

  always @(posedge clk) begin
    r_dm_busy <= dm_memwrite & ~dm_clk_stall;
    if (dm_memwrite && !dm_clk_stall)
      dmem[dm_addr[13:2]] <= merge(dmem[dm_addr[13:2]], dm_addr, dm_write_data, dm_sign_mask);
    if (dm_memread && !dm_clk_stall)
      r_dm_rd <= extract(dmem[dm_addr[13:2]], dm_addr, dm_sign_mask);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $display("FAIL %s: observed=timeout expected=progress", tag);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input bit upd, output int stalls);
    stalls = 0;
    @(negedge clk);
    addr = a; write_data = d; sign_mask = m; memwrite = 1'b1; memread = 1'b0;
    #1;
    while (clk_stall && stalls < 200) begin
      @(negedge clk); #1; stalls++;
    end
    if (stalls >= 200) timeout("store_accept");
    if (upd) ref_mem[a[13:2]] = merge(ref_mem[a[13:2]], a, d, m);
    @(posedge clk); #1;
    memwrite = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [3:0] m,
                      output int stalls);
    stalls = 0;
    @(negedge clk);
    addr = a; sign_mask = m; memread = 1'b1; memwrite = 1'b0;
    #1;
    while (clk_stall && stalls < 200) begin
      @(negedge clk); #1; stalls++;
    end
    if (stalls >= 200) timeout("load_accept");
    exp_q.push_back(extract(ref_mem[a[13:2]], a, m));
    @(posedge clk); #1;
    memread = 1'b0;
    chk(tag, read_data, exp_q.pop_front());
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(dut.w_count == '0 && dut.r_state == DR_IDLE && !dm_clk_stall) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) timeout("drain");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int n;
    logic [31:0] orig;
    for (int i = 0; i < 4096; i++) begin
      dmem[i]    = 32'h5A00_0000 | i;
      ref_mem[i] = 32'h5A00_0000 | i;
    end

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_dm_memwrite", dm_memwrite, 0);
    chk("rst_dm_memread", dm_memread, 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_clk_stall", clk_stall, 0);
    chk("rst_count", dut.w_count, 0);
    @(negedge clk); reset_n = 1'b1;

    // Load to a different word is served ahead of the pending store
    orig = dmem[32'h100 >> 2];
    store(32'h100, 32'hDEADBEEF, M_SW, 1, st);
    chk("sw100_stall", st, 0);
    load("lw200_data", 32'h200, M_LW, st);
    chk("lw200_stall", st, 0);
    chk("sw100_not_drained", dmem[32'h100 >> 2], orig);
    drain();
    load("lw100_data", 32'h100, M_LW, st);

    // Hazard load waits for the drain
    store(32'h40, 32'h12345678, M_SW, 1, st);
    load("lbu41_data", 32'h41, M_LBU, st);
    chk("lbu41_stalled", (st > 0) ? 1 : 0, 1);
    chk("lbu41_value", ref_mem[32'h40 >> 2][15:8], 32'h56);

    // Full queue with drain blocked
    drain();
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      store(32'h300 + 4 * i, 32'hA000_0000 + i, M_SW, 1, st);
      chk("fill_stall", st, 0);
    end
    chk("full_count", dut.w_count, 4);
    orig = dmem[32'h304 >> 2];
    @(negedge clk);
    addr = 32'h310; write_data = 32'hA000_0004; sign_mask = M_SW; memwrite = 1'b1;
    #1;
    chk("fifth_stall", clk_stall, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("fifth_stall_held", clk_stall, 1);
    hold_busy = 1'b0;
    n = 0;
    while (clk_stall && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) timeout("fifth_accept");
    chk("first_pop_landed", dmem[32'h300 >> 2], 32'hA000_0000);
    chk("second_not_landed", dmem[32'h304 >> 2], orig);
    ref_mem[32'h310 >> 2] = 32'hA000_0004;
    @(posedge clk); #1;
    memwrite = 1'b0;
    drain();
    for (int i = 0; i < 5; i++) load("fill_readback", 32'h300 + 4 * i, M_LW, st);

    // LED byte store retires exactly two edges after enqueue
    drain();
    store(LED_ADDR, 32'h0000_00FF, M_SB, 1, st);
    chk("led_at_enqueue", dmem[LED_ADDR >> 2][7:0], 32'h00);
    @(posedge clk); #1;
    chk("led_edge1", dmem[LED_ADDR >> 2][7:0], 32'h00);
    @(posedge clk); #1;
    chk("led_edge2", dmem[LED_ADDR >> 2][7:0], 32'hFF);

    // Same-word stores retire in order
    drain();
    store(32'h500, 32'h1, M_SW, 1, st);
    store(32'h500, 32'h2, M_SW, 1, st);
    store(32'h500, 32'h3, M_SW, 1, st);
    load("same_word_data", 32'h500, M_LW, st);
    chk("same_word_stalled", (st > 0) ? 1 : 0, 1);
    chk("same_word_value", ref_mem[32'h500 >> 2], 32'h3);

    // Reset discards queued stores
    drain();
    hold_busy = 1'b1;
    orig = dmem[32'h600 >> 2];
    store(32'h600, 32'h1111_1111, M_SW, 0, st);
    store(32'h604, 32'h2222_2222, M_SW, 0, st);
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    hold_busy = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("mid_rst_count", dut.w_count, 0);
    chk("mid_rst_memwrite", dm_memwrite, 0);
    chk("mid_rst_clk_stall", clk_stall, 0);
    repeat (8) @(negedge clk);
    chk("mid_rst_mem_kept", dmem[32'h600 >> 2], orig);
    load("mid_rst_load", 32'h600, M_LW, st);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
